// File: rtl/als_sched_pkg.sv
// Shared definitions for the PmodALS sample scheduler.
//   als_state_e  : handshake sequencer states
//   ILLUM_W      : width of one sensor reading
//   AVG_LOG2_DEF : default log2 of samples per average
//   TIMEOUT_DEF  : default handshake watchdog limit in cycles
package als_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_READY = 2'd1,
    FETCH      = 2'd2,
    WAIT_DATA  = 2'd3
  } als_state_e;

  localparam int ILLUM_W      = 8;
  localparam int AVG_LOG2_DEF = 2;
  localparam int TIMEOUT_DEF  = 1000;

endpackage

// File: rtl/als_interval_timer.sv
// Programmable interval timer: emits a one-cycle tick every max(period,1)
// cycles while enabled, and holds the reload value while disabled.
// Ports:
//   Clock  : system clock
//   Reset  : asynchronous active-low reset
//   enable : 1 = count down, 0 = hold at reload value
//   period : cycles between ticks (0 behaves as 1)
//   tick   : registered one-cycle pulse
module als_interval_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] reload;

  // A zero period reloads to 0, which ticks every cycle like period = 1.
  always_comb begin
    reload = (period == '0) ? '0 : period - PERIOD_W'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      cnt_q <= reload;
      tick  <= 1'b0;
    end else if (cnt_q == '0) begin
      cnt_q <= reload;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q - PERIOD_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/als_sample_scheduler.sv
// PmodALS sample scheduler: requests one sensor reading per interval through
// the ready/fetch/arrived handshake, box-car averages 2^AVG_LOG2 readings,
// drives a hysteretic dark flag and watchdogs the handshake.
// Ports:
//   Clock, Reset        : system clock, asynchronous active-low reset
//   enable              : 1 = periodic sampling active
//   period              : cycles between fetch requests (0 behaves as 1)
//   thr_low, thr_high   : dark set / clear thresholds
//   clr_err             : synchronous clear of timeout_err and overrun
//   als_ready           : sensor controller idle
//   als_fetch           : one-cycle fetch request
//   als_arrived         : sensor result valid
//   als_illum           : sensor reading
//   avg, avg_valid      : latest average and its one-cycle update pulse
//   dark                : hysteretic dark indication
//   timeout_err         : sticky handshake-stall flag
//   overrun             : sticky flag, interval tick while one was pending
module als_sample_scheduler
  import als_sched_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ILLUM_W-1:0]  thr_low,
  input  logic [ILLUM_W-1:0]  thr_high,
  input  logic                clr_err,
  input  logic                als_ready,
  output logic                als_fetch,
  input  logic                als_arrived,
  input  logic [ILLUM_W-1:0]  als_illum,
  output logic [ILLUM_W-1:0]  avg,
  output logic                avg_valid,
  output logic                dark,
  output logic                timeout_err,
  output logic                overrun
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = ILLUM_W + AVG_LOG2;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = AVG_LOG2'(N - 1);

  // Truncating divide of the accumulated sum by N.
  function automatic logic [ILLUM_W-1:0] avg_trunc(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] sh;
    sh = s >> AVG_LOG2;
    return sh[ILLUM_W-1:0];
  endfunction

  // Hysteresis: the set test comes first so it wins when thr_low > thr_high.
  function automatic logic dark_next(input logic [ILLUM_W-1:0] a, lo, hi,
                                     input logic cur);
    if (a < lo)      return 1'b1;
    else if (a > hi) return 1'b0;
    else             return cur;
  endfunction

  als_state_e          state_q;
  logic [TO_W-1:0]     to_q;
  logic                tick;
  logic                pending_q;
  logic                keep_q;
  logic [SUM_W-1:0]    sum_q;
  logic [AVG_LOG2-1:0] cnt_q;

  logic                take;
  logic                accept;
  logic                to_hit;
  logic                to_fire;
  logic [SUM_W-1:0]    sum_add;
  logic [ILLUM_W-1:0]  avg_new;

  als_interval_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  // keep_q marks a transaction whose sample may still be used; any cycle
  // with enable low during the transaction discards its sample.
  always_comb begin
    take    = (state_q == IDLE) && pending_q && enable;
    accept  = (state_q == WAIT_DATA) && als_arrived && keep_q && enable;
    to_hit  = (to_q == TO_LAST);
    to_fire = to_hit && (((state_q == WAIT_READY) && !als_ready) ||
                         ((state_q == WAIT_DATA)  && !als_arrived));
    sum_add = sum_q + SUM_W'(als_illum);
    avg_new = avg_trunc(sum_add);
  end

  // Handshake sequencer with watchdog counter and registered fetch strobe.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      to_q      <= '0;
      als_fetch <= 1'b0;
      keep_q    <= 1'b0;
    end else begin
      als_fetch <= 1'b0;
      if (!enable) keep_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q <= WAIT_READY;
            to_q    <= '0;
            keep_q  <= 1'b1;
          end
        end
        WAIT_READY: begin
          if (als_ready) begin
            state_q   <= FETCH;
            als_fetch <= 1'b1;
          end else if (to_hit) begin
            state_q <= IDLE;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        FETCH: begin
          state_q <= WAIT_DATA;
          to_q    <= '0;
        end
        WAIT_DATA: begin
          if (als_arrived || to_hit) begin
            state_q <= IDLE;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tick pending flag and sticky error flags; a set beats a same-edge clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_q   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (!enable)   pending_q <= 1'b0;
      else if (tick) pending_q <= 1'b1;
      else if (take) pending_q <= 1'b0;

      if (enable && tick && pending_q && !take) overrun <= 1'b1;
      else if (clr_err)                         overrun <= 1'b0;

      if (to_fire)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  // Box-car accumulator, average output and dark hysteresis.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      dark      <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (!enable || to_fire) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        if (cnt_q != CNT_LAST) begin
          sum_q <= sum_add;
          cnt_q <= cnt_q + AVG_LOG2'(1);
        end else begin
          avg       <= avg_new;
          avg_valid <= 1'b1;
          dark      <= dark_next(avg_new, thr_low, thr_high, dark);
          sum_q     <= '0;
          cnt_q     <= '0;
        end
      end
    end
  end

endmodule

// File: doc/als_sample_scheduler.md
Name: als_sample_scheduler

Overview:
- Sequences the PmodALS SPI light-sensor controller through its ready/fetch/arrived/illum handshake.
- Issues one fetch per programmable interval and box-car averages 2^AVG_LOG2 readings.
- Drives a hysteretic "dark" flag for the alarm logic.
- Watchdogs the handshake and flags stalls and interval overruns.

Parameters:
PERIOD_W, 24, width of the sample-interval register and counter
AVG_LOG2, 2, log2 of the number of samples per average (N = 4 by default)
TIMEOUT, 1000, maximum cycles spent in WAIT_READY or WAIT_DATA before abandoning the fetch

Ports:
Clock  in  1  system clock; all logic on posedge
Reset  in  1  asynchronous, active-low reset
enable  in  1  1 = periodic sampling active
period  in  PERIOD_W  cycles between fetch requests; 0 is treated as 1
thr_low  in  8  dark set threshold
thr_high  in  8  dark clear threshold
clr_err  in  1  synchronous clear of timeout_err and overrun
als_ready  in  1  sensor controller idle
als_fetch  out  1  single-cycle fetch request to the sensor controller
als_arrived  in  1  sensor controller result valid
als_illum  in  8  sensor reading
avg  out  8  latest average
avg_valid  out  1  one-cycle pulse when avg updates
dark  out  1  hysteretic dark indication
timeout_err  out  1  sticky: handshake stall detected
overrun  out  1  sticky: interval tick occurred while a tick was already pending

Behaviour:
- Reset (Reset = 0, asynchronous): all state and outputs clear to 0; state = IDLE. als_fetch drops immediately, including mid-transaction.
- Interval timer:
  - While enable = 1, counts down from max(period,1)-1.
  - At 0 it emits a one-cycle tick and reloads.
  - While enable = 0 it holds the reload value.
- Tick pending:
  - A tick sets a 1-deep pending flag.
  - A tick arriving while pending = 1 sets overrun; the extra tick is dropped.
  - The pending flag clears on the IDLE->WAIT_READY transition.
- FSM:
  - IDLE: pending & enable -> WAIT_READY.
  - WAIT_READY: als_ready -> FETCH; otherwise timeout -> IDLE.
  - FETCH: als_fetch = 1 for exactly this one cycle; -> WAIT_DATA unconditionally.
  - WAIT_DATA: als_arrived -> IDLE, capturing als_illum; otherwise timeout -> IDLE.
- Fetch rules: als_fetch is registered and is never asserted outside FETCH. Fetch is issued only after als_ready has been sampled high.
- Timeout:
  - The counter resets on entering WAIT_READY or WAIT_DATA.
  - It reaches TIMEOUT while still in that state -> timeout_err = 1, return to IDLE, clear accumulator and count.
  - timeout_err and overrun clear only on clr_err = 1 or reset. If a set and clr_err occur on the same edge, the set wins.
- Accumulator:
  - sum is 8+AVG_LOG2 bits and never overflows; cnt is AVG_LOG2 bits.
  - On the edge that samples als_arrived = 1 in WAIT_DATA:
    - if cnt < N-1: sum += als_illum, cnt++;
    - else (the N-th sample) on that same edge: avg <= (sum + als_illum) >> AVG_LOG2 (truncating), avg_valid <= 1 for one cycle, sum <= 0, cnt <= 0.
- Dark hysteresis:
  - Updated on the same edge as avg, using the new average value.
  - new < thr_low -> dark = 1; else new > thr_high -> dark = 0; else hold.
  - If thr_low > thr_high, the set condition has priority.
- enable = 0:
  - pending is cleared; sum and cnt are cleared.
  - An in-flight fetch (FETCH/WAIT_DATA) runs to completion, but its sample is discarded.
  - avg and dark hold their values.
- als_arrived outside WAIT_DATA is ignored.

Decomposition:
- Package als_sched_pkg holds:
  - state enum (IDLE, WAIT_READY, FETCH, WAIT_DATA);
  - ILLUM_W = 8;
  - the default constants for AVG_LOG2 and TIMEOUT.
- Sub-module als_interval_timer (period reload counter plus tick output) is the natural split. The FSM, watchdog, accumulator and hysteresis stay in the top module.

Test Plan:
- Averaging: AVG_LOG2 = 2, period = 50, sensor model returns 0x40, 0x44, 0x48, 0x4C -> exactly one avg_valid pulse with avg = 0x46, aligned to the 4th arrival edge; 4 single-cycle fetches, each ≥ 1 cycle after als_ready was high.
- Hysteresis: thr_low = 0x20, thr_high = 0x30.
  - Four 0x10 readings -> dark = 1.
  - Four 0x28 readings -> dark stays 1.
  - Four 0x31 readings -> dark = 0.
  - thr_low = 0x40, thr_high = 0x10 with avg 0x30 -> dark = 1 (set priority).
- Timeout:
  - Hold als_ready = 0 -> after TIMEOUT cycles timeout_err = 1, no fetch issued.
  - Release als_ready -> next tick fetches normally.
  - clr_err -> timeout_err = 0.
  - Repeat the same check with als_arrived withheld in WAIT_DATA.
- Overrun: period = 5, sensor latency 20 cycles -> overrun = 1, fetches spaced by completion (back-to-back, no stacked requests), averages still correct.
- Reset/enable mid-operation:
  - Assert Reset low in WAIT_DATA -> als_fetch, avg, avg_valid, dark, timeout_err and overrun all 0 at once; a late als_arrived after release is ignored.
  - Drop enable after 2 samples -> the next enabled window needs 4 fresh samples before avg_valid.
